seg_scan_ctrl: RTL and testbench

Time-multiplexes a single seg_display decoder across NUM_DIGITS stopwatch digits.
- Drives the decoder's hex_in from a per-digit nibble and a one-hot digit select.
- Inserts blanking guard cycles between digits to prevent ghosting.
- Snapshots the digit bus once per frame so the display never tears.
- Supports leading-zero suppression.
- Sits between the stopwatch BCD counters and seg_display.

---
 rtl/seg_scan_ctrl.sv | 198 +++++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : seg_scan_ctrl
//  Description : Time-multiplexes one seven-segment decoder across
//                NUM_DIGITS stopwatch digits. Each digit slot starts with a
//                few blanking cycles (all digits off) before the selected
//                digit is lit, which prevents ghosting. The digit bus is
//                captured into a shadow register once per frame so a frame
//                never mixes old and new digits. Optional leading-zero
//                suppression and a freeze (lap hold) input are provided.
//  Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl #(
    parameter int NUM_DIGITS   = 4,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 8
) (
    input  logic                          sys_clk,
    input  logic                          reset_n,
    input  logic                          disp_en,
    input  logic                          cfg_cathode_mode,
    input  logic                          lz_en,
    input  logic                          freeze,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    output logic [3:0]                    hex_out,
    output logic [NUM_DIGITS-1:0]         digit_en,
    output logic [$clog2(NUM_DIGITS)-1:0] scan_idx,
    output logic                          frame_start
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_CNT_W = $clog2(SCAN_DIV);

    // Last blank cycle of a slot: the digit lights on the following cycle.
    localparam logic [c_CNT_W-1:0] c_BLANK_LAST = c_CNT_W'(BLANK_CYCLES - 1);
    // Last cycle of a slot: the next slot (and possibly frame) begins after it.
    localparam logic [c_CNT_W-1:0] c_SLOT_LAST  = c_CNT_W'(SCAN_DIV - 1);
    // Highest digit index; stepping past it wraps to digit 0 and a new frame.
    localparam logic [c_IDX_W-1:0] c_LAST_IDX   = c_IDX_W'(NUM_DIGITS - 1);

    // ------------------------------------------------------------------------
    // Scan state machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_BLANK = 2'd1,
        ST_SHOW  = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t                    r_state;
    logic [c_CNT_W-1:0]        r_cnt;
    logic [c_IDX_W-1:0]        r_idx;
    logic [4*NUM_DIGITS-1:0]   r_shadow;
    logic [3:0]                r_hex;
    logic [NUM_DIGITS-1:0]     r_act;
    logic                      r_frame_start;

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic [3:0]                w_nib [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]     w_upper_zero;
    logic [NUM_DIGITS-1:0]     w_supp;
    logic                      w_last_idx;
    logic [c_IDX_W-1:0]        w_next_idx;
    logic [4*NUM_DIGITS-1:0]   w_snap;
    logic [NUM_DIGITS-1:0]     w_onehot;
    logic                      w_cur_supp;

    // Split the shadow register into per-digit nibbles for indexed access.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
            assign w_nib[gi] = r_shadow[4*gi +: 4];
        end
    endgenerate

    // A digit is a leading zero when it and every more significant digit are
    // zero. Digit 0 is never suppressed so a zero reading still shows "0".
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_supp
            assign w_upper_zero[gi] = ~|r_shadow[4*NUM_DIGITS-1:4*gi];
            if (gi == 0) begin : g_lsd
                assign w_supp[gi] = 1'b0;
            end else begin : g_upper
                assign w_supp[gi] = lz_en & w_upper_zero[gi];
            end
        end
    endgenerate

    // Next digit index wraps explicitly so non-power-of-two digit counts work.
    assign w_last_idx = (r_idx == c_LAST_IDX);
    assign w_next_idx = w_last_idx ? '0 : r_idx + 1'b1;

    // Value the shadow will hold after a snapshot; freeze keeps the lap value.
    assign w_snap = freeze ? r_shadow : digits_in;

    // One-hot select of the digit owning the current slot.
    assign w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;

    // Suppression of the current slot's digit, judged from the frame snapshot.
    assign w_cur_supp = w_supp[r_idx];

    // ------------------------------------------------------------------------
    // Scan sequencer: slot timing, digit stepping, snapshot and hex_out.
    // hex_out is only ever loaded at slot start while every digit is dark.
    // ------------------------------------------------------------------------
    always_ff @(posedge sys_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= ST_OFF;
            r_cnt         <= '0;
            r_idx         <= '0;
            r_shadow      <= '0;
            r_hex         <= '0;
            r_act         <= '0;
            r_frame_start <= 1'b0;
        end else begin
            r_frame_start <= 1'b0;
            if (!disp_en) begin
                // Display off wins over everything; shadow is kept so a
                // frozen lap value survives a display blank.
                r_state <= ST_OFF;
                r_cnt   <= '0;
                r_idx   <= '0;
                r_hex   <= '0;
                r_act   <= '0;
            end else begin
                case (r_state)
                    ST_OFF: begin
                        // Enable always begins a fresh frame at digit 0.
                        r_state       <= ST_BLANK;
                        r_cnt         <= '0;
                        r_idx         <= '0;
                        r_act         <= '0;
                        r_shadow      <= w_snap;
                        r_hex         <= w_snap[3:0];
                        r_frame_start <= 1'b1;
                    end

                    ST_BLANK: begin
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_BLANK_LAST) begin
                            r_state <= ST_SHOW;
                            r_act   <= w_cur_supp ? '0 : w_onehot;
                        end else begin
                            r_act   <= '0;
                        end
                    end

                    ST_SHOW: begin
                        if (r_cnt == c_SLOT_LAST) begin
                            r_cnt   <= '0;
                            r_act   <= '0;
                            r_state <= ST_BLANK;
                            r_idx   <= w_next_idx;
                            if (w_last_idx) begin
                                // Frame boundary: capture the digit bus and
                                // present digit 0 of the new snapshot.
                                r_shadow      <= w_snap;
                                r_hex         <= w_snap[3:0];
                                r_frame_start <= 1'b1;
                            end else begin
                                r_hex         <= w_nib[w_next_idx];
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end

                    default: begin
                        // Unreachable encoding: recover to a dark display.
                        r_state <= ST_OFF;
                        r_cnt   <= '0;
                        r_idx   <= '0;
                        r_hex   <= '0;
                        r_act   <= '0;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs. Digit select polarity follows the cathode mode directly so a
    // mode change needs no state update.
    // ------------------------------------------------------------------------
    assign digit_en    = r_act ^ {NUM_DIGITS{cfg_cathode_mode}};
    assign hex_out     = r_hex;
    assign scan_idx    = r_idx;
    assign frame_start = r_frame_start;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seg_scan_ctrl
//  Description : Scoreboard bench for seg_scan_ctrl. A time-based reference
//                model (elapsed cycles since enable -> slot, digit, offset)
//                pushes the expected outputs for every clock edge; a monitor
//                on the falling edge pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 10;
    localparam int BLK = 2;

    logic        sys_clk          = 1'b0;
    logic        reset_n          = 1'b1;
    logic        disp_en          = 1'b0;
    logic        cfg_cathode_mode = 1'b1;
    logic        lz_en            = 1'b0;
    logic        freeze           = 1'b0;
    logic [15:0] digits_in        = 16'h0000;
    logic [3:0]  hex_out;
    logic [3:0]  digit_en;
    logic [1:0]  scan_idx;
    logic        frame_start;

    seg_scan_ctrl #(
        .NUM_DIGITS   (N),
        .SCAN_DIV     (DIV),
        .BLANK_CYCLES (BLK)
    ) u_dut (
        .sys_clk          (sys_clk),
        .reset_n          (reset_n),
        .disp_en          (disp_en),
        .cfg_cathode_mode (cfg_cathode_mode),
        .lz_en            (lz_en),
        .freeze           (freeze),
        .digits_in        (digits_in),
        .hex_out          (hex_out),
        .digit_en         (digit_en),
        .scan_idx         (scan_idx),
        .frame_start      (frame_start)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [3:0] hex;
        logic [3:0] act;
        logic [1:0] idx;
        logic       fs;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state: m_t = cycles since display enable (-1 when off).
    int          m_t      = -1;
    logic [15:0] m_shadow = 16'h0000;
    logic [3:0]  m_hex    = 4'h0;
    logic [3:0]  m_act    = 4'h0;
    int          m_idx    = 0;
    logic        m_fs     = 1'b0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, got, exp);
        end
    endtask

    // Leading-zero rule: digit d (d>0) blank when it and all higher digits are 0.
    function automatic logic suppressed(input int d);
        return lz_en && (d != 0) && ((m_shadow >> (4*d)) == 16'h0);
    endfunction

    // Advance the model by one clock edge using the inputs present at the edge.
    task automatic model_edge();
        int   pos;
        int   digit;
        exp_t e;
        if (!reset_n) begin
            m_t = -1; m_shadow = '0; m_hex = '0; m_act = '0; m_idx = 0; m_fs = 1'b0;
        end else if (!disp_en) begin
            m_t = -1; m_hex = '0; m_act = '0; m_idx = 0; m_fs = 1'b0;
        end else begin
            m_t   = (m_t < 0) ? 0 : m_t + 1;
            pos   = m_t % DIV;
            digit = (m_t / DIV) % N;
            m_idx = digit;
            m_fs  = 1'b0;
            if (pos == 0) begin
                if (digit == 0) begin
                    if (!freeze) m_shadow = digits_in;
                    m_fs = 1'b1;
                end
                m_hex = m_shadow[4*digit +: 4];
                m_act = '0;
            end else if (pos < BLK) begin
                m_act = '0;
            end else if (pos == BLK) begin
                m_act = suppressed(digit) ? 4'h0 : (4'h1 << digit);
            end
        end
        e.hex = m_hex;
        e.act = m_act;
        e.idx = 2'(m_idx);
        e.fs  = m_fs;
        q.push_back(e);
    endtask

    task automatic cyc(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge sys_clk);
            model_edge();
            #1;
        end
    endtask

    // Monitor: one expected record per edge, compared mid-cycle.
    always @(negedge sys_clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("hex_out",     32'(hex_out),     32'(e.hex));
            check("digit_en",    32'(digit_en),    32'(e.act ^ {4{cfg_cathode_mode}}));
            check("scan_idx",    32'(scan_idx),    32'(e.idx));
            check("frame_start", 32'(frame_start), 32'(e.fs));
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hex"},      32'(hex_out),     32'h0);
        check({tag, "_digit_en"}, 32'(digit_en),    32'({4{cfg_cathode_mode}}));
        check({tag, "_idx"},      32'(scan_idx),    32'h0);
        check({tag, "_fs"},       32'(frame_start), 32'h0);
    endtask

    initial begin
        int guard;
        // Power-on reset with a real falling edge on reset_n.
        #1 reset_n = 1'b0;
        #1 check_reset_outputs("por");
        cyc(3);
        reset_n = 1'b1;
        cyc(1);

        // Basic scan, common cathode then common anode.
        disp_en   = 1'b1;
        digits_in = 16'h1234;
        cyc(85);
        cfg_cathode_mode = 1'b0;
        cyc(45);

        // Leading-zero suppression.
        lz_en     = 1'b1;
        digits_in = 16'h0070;
        cyc(80);
        digits_in = 16'h0000;
        cyc(80);
        lz_en     = 1'b0;

        // Mid-frame digit change is deferred to the next frame.
        digits_in = 16'h1234;
        cyc(40);
        guard = 0;
        while (!(m_idx == 1 && (m_t % DIV) == 5) && guard < 200) begin
            cyc(1);
            guard++;
        end
        check("reach_idx1", 32'(guard < 200), 32'h1);
        digits_in = 16'h5678;
        cyc(80);

        // Freeze holds the lap value across frames.
        freeze    = 1'b1;
        digits_in = 16'h9999;
        cyc(120);
        freeze    = 1'b0;
        cyc(80);

        // Drop disp_en mid-SHOW at idx 2, then re-enable.
        guard = 0;
        while (!(m_idx == 2 && (m_t % DIV) == 6) && guard < 200) begin
            cyc(1);
            guard++;
        end
        check("reach_idx2", 32'(guard < 200), 32'h1);
        disp_en = 1'b0;
        cyc(3);
        disp_en = 1'b1;
        cyc(15);

        // Asynchronous reset mid-BLANK.
        guard = 0;
        while (!((m_t % DIV) == 0 && m_t > 0) && guard < 200) begin
            cyc(1);
            guard++;
        end
        check("reach_blank", 32'(guard < 200), 32'h1);
        #2 reset_n = 1'b0;
        q.delete();
        #1 check_reset_outputs("async_rst");
        cyc(2);
        reset_n = 1'b1;
        cyc(2);

        // Randomized stimulus with zero-biased digits to exercise suppression.
        for (int r = 0; r < 1500; r++) begin
            if ($urandom_range(0, 29) == 0) begin
                for (int d = 0; d < N; d++)
                    digits_in[4*d +: 4] = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
            end
            if ($urandom_range(0, 99) == 0)  freeze           = ~freeze;
            if ($urandom_range(0, 79) == 0)  lz_en            = ~lz_en;
            if ($urandom_range(0, 99) == 0)  cfg_cathode_mode = ~cfg_cathode_mode;
            if (disp_en) begin
                if ($urandom_range(0, 199) == 0) disp_en = 1'b0;
            end else if ($urandom_range(0, 3) == 0) begin
                disp_en = 1'b1;
            end
            cyc(1);
        end

        @(negedge sys_clk);
        #1;
        check("queue_drained", 32'(q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
